// File: rtl/noc_credit_rx_buffer.sv
// Credit-link receive buffer: stores flits until popped, returns one credit per pop, flags link overflow and mid-packet dest changes.
// Head visible the cycle after push; credit one cycle after pop. Optional pkt_count via NOC_RX_PKT_COUNT_EN.
module noc_credit_rx_buffer #(
  parameter int FLIT_WIDTH   = 32,
  parameter int DEST_WIDTH   = 4,
  parameter int BUFFER_DEPTH = 4
) (
  input  logic                                clk_noc,
  input  logic                                rst_noc_sync,
  input  logic [FLIT_WIDTH-1:0]               data_in,
  input  logic [DEST_WIDTH-1:0]               dest_in,
  input  logic                                is_tail_in,
  input  logic                                send_in,
  output logic                                credit_out,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [FLIT_WIDTH-1:0]               out_data,
  output logic [DEST_WIDTH-1:0]               out_dest,
  output logic                                out_is_tail,
  output logic [$clog2(BUFFER_DEPTH+1)-1:0]   occupancy,
  output logic                                overflow_err,
  output logic                                framing_err,
  output logic [15:0]                         pkt_count
);

  localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUFFER_DEPTH+1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUFFER_DEPTH-1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUFFER_DEPTH);

  typedef enum logic {ST_IDLE, ST_BODY} state_t;

  logic [FLIT_WIDTH-1:0] r_data_mem [BUFFER_DEPTH];
  logic [DEST_WIDTH-1:0] r_dest_mem [BUFFER_DEPTH];
  logic                  r_tail_mem [BUFFER_DEPTH];

  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic                  r_credit;
  logic                  r_overflow_err;
  logic                  r_framing_err;
  logic [DEST_WIDTH-1:0] r_head_dest;
  state_t                r_state;
  state_t                w_state_nxt;

  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;
  logic w_frame_bad;

  assign w_full = (r_count == FULL_CNT);
  assign w_pop  = out_valid && out_ready;
  // A full FIFO still accepts a flit when the head leaves in the same cycle.
  assign w_push = send_in && (!w_full || w_pop);
  assign w_drop = send_in && w_full && !w_pop;

  assign out_valid    = (r_count != '0);
  assign out_data     = r_data_mem[r_rd_ptr];
  assign out_dest     = r_dest_mem[r_rd_ptr];
  assign out_is_tail  = r_tail_mem[r_rd_ptr];
  assign occupancy    = r_count;
  assign credit_out   = r_credit;
  assign overflow_err = r_overflow_err;
  assign framing_err  = r_framing_err;

  always_ff @(posedge clk_noc) begin
    if (w_push) begin
      r_data_mem[r_wr_ptr] <= data_in;
      r_dest_mem[r_wr_ptr] <= dest_in;
      r_tail_mem[r_wr_ptr] <= is_tail_in;
    end
  end

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_credit       <= 1'b0;
      r_overflow_err <= 1'b0;
      r_framing_err  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_credit       <= w_pop;
      r_overflow_err <= r_overflow_err | w_drop;
      r_framing_err  <= r_framing_err | w_frame_bad;
    end
  end

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) begin
      r_state     <= ST_IDLE;
      r_head_dest <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push && (r_state == ST_IDLE) && !is_tail_in) r_head_dest <= dest_in;
    end
  end

  // Only accepted pushes advance framing; dropped flits are invisible here.
  always_comb begin
    w_state_nxt = r_state;
    w_frame_bad = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_push && !is_tail_in) w_state_nxt = ST_BODY;
      end
      ST_BODY: begin
        if (w_push) begin
          if (dest_in != r_head_dest) w_frame_bad = 1'b1;
          if (is_tail_in) w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef NOC_RX_PKT_COUNT_EN
  logic [15:0] r_pkt_count;

  always_ff @(posedge clk_noc) begin
    if (rst_noc_sync) r_pkt_count <= 16'd0;
    else if (w_pop && out_is_tail) r_pkt_count <= r_pkt_count + 16'd1;
  end

  assign pkt_count = r_pkt_count;
`else
  assign pkt_count = 16'd0;
`endif

endmodule
